// File: rtl/cmd_script_seq_pkg.sv
// Shared types and constants for the MazeRunner command script sequencer.
// Holds the controller state encoding, the failure causes and the command opcodes.
package cmd_script_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_SENT,
    S_WAIT_RESP,
    S_NEXT,
    S_FINISH
  } seq_state_t;

  typedef enum logic [1:0] {
    FC_NONE  = 2'b00,
    FC_NAK   = 2'b01,
    FC_TMO   = 2'b10,
    FC_ABORT = 2'b11
  } fail_code_t;

  localparam logic [7:0] ACK_VAL_DEF = 8'hA5;

  // MazeRunner opcodes occupy the top nibble of a 16-bit command.
  localparam logic [3:0] OP_CAL   = 4'h0;
  localparam logic [3:0] OP_HDNG  = 4'h2;
  localparam logic [3:0] OP_MOVE  = 4'h4;
  localparam logic [3:0] OP_SOLVE = 4'h6;

  function automatic logic [15:0] mk_cmd(input logic [3:0] op, input logic [11:0] arg);
    return {op, arg};
  endfunction

endpackage

// File: rtl/cmd_script_seq_script_ram.sv
// Script storage: one write port, one registered read port.
// Deliberately unreset so a loaded script survives rst_n.
module cmd_script_seq_script_ram #(
  parameter int DEPTH = 8,
  parameter int W     = 20
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cmd_script_seq.sv
// Plays a stored script of commands into RemoteComm, checking each for an ACK
// within a per-entry timeout, with bounded retry. Reports pass / failing entry / cause.
module cmd_script_seq
  import cmd_script_seq_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter int          CMD_W     = 16,
  parameter int          RESP_W    = 8,
  parameter logic [RESP_W-1:0] ACK_VAL = RESP_W'(ACK_VAL_DEF),
  parameter int          TO_BASE   = 10,
  parameter int          MAX_RETRY = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [CMD_W+3:0]         wr_data,
  input  logic [$clog2(DEPTH):0]   len,
  input  logic                     start,
  input  logic                     abort,
  output logic [CMD_W-1:0]         cmd,
  output logic                     send_cmd,
  input  logic                     cmd_sent,
  input  logic                     resp_rdy,
  input  logic [RESP_W-1:0]        resp,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [$clog2(DEPTH)-1:0] fail_idx,
  output logic [1:0]               fail_code
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = TO_BASE + 15;
  localparam logic [1:0] MAX_R = MAX_RETRY[1:0];

  seq_state_t       state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [AW:0]      len_q, len_d;
  logic [1:0]       retry_q, retry_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             send_q, send_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [AW-1:0]    fail_idx_q, fail_idx_d;
  fail_code_t       fail_code_q, fail_code_d;

  logic [CMD_W+3:0] rd_data;
  logic [3:0]       rd_exp;
  logic [TW-1:0]    tmo_load;
  logic             ram_we;

  // Writes only land while idle, so the script cannot change under a run.
  assign ram_we = wr_en && (state_q == S_IDLE);

  cmd_script_seq_script_ram #(.DEPTH(DEPTH), .W(CMD_W + 4)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (idx_q),
    .rdata (rd_data)
  );

  assign rd_exp = rd_data[CMD_W+3:CMD_W];
  // 2^(TO_BASE+exp)-1; the exp=15 case shifts everything out and yields all ones.
  assign tmo_load = ~({TW{1'b1}} << (TO_BASE + int'(rd_exp)));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    retry_d     = retry_q;
    timer_d     = timer_q;
    cmd_d       = cmd_q;
    send_d      = 1'b0;
    pass_d      = pass_q;
    fail_idx_d  = fail_idx_q;
    fail_code_d = fail_code_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pass_d      = 1'b0;
          fail_code_d = FC_NONE;
          fail_idx_d  = '0;
          idx_d       = '0;
          len_d       = len;
          if (len == '0) begin
            pass_d  = 1'b1;
            state_d = S_FINISH;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        retry_d = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        cmd_d   = rd_data[CMD_W-1:0];
        send_d  = 1'b1;
        timer_d = tmo_load;
        state_d = S_WAIT_SENT;
      end
      S_WAIT_SENT, S_WAIT_RESP: begin
        timer_d = timer_q - 1'b1;
        if ((state_q == S_WAIT_RESP) && resp_rdy) begin
          if (resp == ACK_VAL) begin
            state_d = S_NEXT;
          end else begin
            fail_code_d = FC_NAK;
            fail_idx_d  = idx_q;
            state_d     = S_FINISH;
          end
        end else if (timer_q == '0) begin
          if (retry_q < MAX_R) begin
            retry_d = retry_q + 1'b1;
            state_d = S_SEND;
          end else begin
            fail_code_d = FC_TMO;
            fail_idx_d  = idx_q;
            state_d     = S_FINISH;
          end
        end else if ((state_q == S_WAIT_SENT) && cmd_sent) begin
          state_d = S_WAIT_RESP;
        end
      end
      S_NEXT: begin
        if ({1'b0, idx_q} == (len_q - 1'b1)) begin
          pass_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Abort overrides whatever the step above decided, including a pending send.
    if (abort && (state_q != S_IDLE) && (state_q != S_FINISH)) begin
      state_d     = S_FINISH;
      send_d      = 1'b0;
      cmd_d       = cmd_q;
      pass_d      = 1'b0;
      fail_code_d = FC_ABORT;
      fail_idx_d  = idx_q;
    end

    done_d = (state_d == S_FINISH);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      retry_q     <= '0;
      timer_q     <= '0;
      cmd_q       <= '0;
      send_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_idx_q  <= '0;
      fail_code_q <= FC_NONE;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      cmd_q       <= cmd_d;
      send_q      <= send_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_idx_q  <= fail_idx_d;
      fail_code_q <= fail_code_d;
    end
  end

  assign cmd       = cmd_q;
  assign send_cmd  = send_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_idx  = fail_idx_q;
  assign fail_code = fail_code_q;

endmodule

// File: tb/tb_cmd_script_seq.sv
// Bench for cmd_script_seq: a RemoteComm responder plays a per-send response plan,
// and an entry-level model predicts the send list and the run outcome.
module tb_cmd_script_seq;

  localparam int MAX_RETRY = 1;
  // Response plan codes, one per send_cmd pulse.
  localparam int R_ACK = 0, R_NAK = 1, R_NONE = 2, R_STALE = 3;

  logic        clk, rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [19:0] wr_data;
  logic [3:0]  len;
  logic        start, abort;
  logic [15:0] cmd;
  logic        send_cmd, cmd_sent, resp_rdy;
  logic [7:0]  resp;
  logic        busy, done, pass;
  logic [2:0]  fail_idx;
  logic [1:0]  fail_code;

  cmd_script_seq #(
    .DEPTH(8), .CMD_W(16), .RESP_W(8), .ACK_VAL(8'hA5), .TO_BASE(4), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len), .start(start), .abort(abort), .cmd(cmd), .send_cmd(send_cmd),
    .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp), .busy(busy), .done(done),
    .pass(pass), .fail_idx(fail_idx), .fail_code(fail_code)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cyc;

  logic [15:0] m_cmd [8];
  logic [3:0]  m_exp [8];
  logic [15:0] exp_q [$];
  logic [15:0] sent_q [$];
  int          sent_t [$];
  int          rc_plan [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RemoteComm stand-in: acknowledges transmission, then answers per the plan.
  initial begin
    int mode, d;
    cmd_sent = 1'b0;
    resp_rdy = 1'b0;
    resp     = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && send_cmd) begin
        sent_q.push_back(cmd);
        sent_t.push_back(cyc);
        mode = (rc_plan.size() > 0) ? rc_plan.pop_front() : R_ACK;
        d = $urandom_range(2, 6);
        if (mode == R_STALE) begin
          resp_rdy = 1'b1;
          resp     = 8'hA5;
          @(negedge clk);
          resp_rdy = 1'b0;
        end
        for (int i = 0; i < d && rst_n; i++) @(negedge clk);
        if (rst_n) begin
          cmd_sent = 1'b1;
          @(negedge clk);
          cmd_sent = 1'b0;
        end
        if ((mode == R_ACK || mode == R_NAK) && rst_n) begin
          d = $urandom_range(40, 60);
          for (int i = 0; i < d && rst_n; i++) @(negedge clk);
          if (rst_n) begin
            resp_rdy = 1'b1;
            resp     = (mode == R_ACK) ? 8'hA5 : 8'h5A;
            @(negedge clk);
            resp_rdy = 1'b0;
          end
        end
      end
    end
  end

  task automatic wr_entry(input int a, input logic [3:0] e, input logic [15:0] c);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a[2:0];
    wr_data = {e, c};
    @(negedge clk);
    wr_en   = 1'b0;
    m_cmd[a] = c;
    m_exp[a] = e;
  endtask

  // Entry-level model: each entry is retried on silence until retries run out.
  task automatic model_run(input int n_len, input int plan[$], output logic e_pass,
                           output logic [1:0] e_code, output logic [2:0] e_idx);
    int k, att, mode;
    bit stop;
    exp_q.delete();
    k = 0; e_pass = 1'b1; e_code = 2'b00; e_idx = 3'd0; stop = 0;
    for (int e = 0; e < n_len && !stop; e++) begin
      att = 0;
      forever begin
        mode = (k < plan.size()) ? plan[k] : R_ACK;
        k++;
        exp_q.push_back(m_cmd[e]);
        if (mode == R_ACK) break;
        if (mode == R_NAK) begin
          e_pass = 1'b0; e_code = 2'b01; e_idx = e[2:0]; stop = 1;
          break;
        end
        if (att < MAX_RETRY) begin
          att++;
        end else begin
          e_pass = 1'b0; e_code = 2'b10; e_idx = e[2:0]; stop = 1;
          break;
        end
      end
    end
  endtask

  task automatic wait_done(input string tag);
    int cnt = 0;
    while (!done && cnt < 20000) begin
      @(negedge clk);
      cnt++;
    end
    done_cyc = cyc;
    check({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic check_sends(input string tag);
    check({tag, "_nsend"}, sent_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
      check($sformatf("%s_cmd%0d", tag, i), {16'd0, sent_q[i]}, {16'd0, exp_q[i]});
  endtask

  task automatic run_check(input int n_len, input int plan[$], input string tag);
    logic ep;
    logic [1:0] ec;
    logic [2:0] ei;
    model_run(n_len, plan, ep, ec, ei);
    rc_plan = plan;
    sent_q.delete();
    sent_t.delete();
    @(negedge clk);
    len   = n_len[3:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(tag);
    check({tag, "_pass"}, {31'd0, pass}, {31'd0, ep});
    check({tag, "_code"}, {30'd0, fail_code}, {30'd0, ec});
    if (!ep) check({tag, "_idx"}, {29'd0, fail_idx}, {29'd0, ei});
    check_sends(tag);
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  task automatic wait_sends(input int n, input string tag);
    int cnt = 0;
    while (sent_q.size() < n && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_reach"}, {31'd0, (sent_q.size() >= n)}, 32'd1);
  endtask

  initial begin
    int plan[$];
    int gap, n_len;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    len = '0; start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy_done_send", {29'd0, busy, done, send_cmd}, 32'd0);
    check("rst_pass_code", {29'd0, pass, fail_code}, 32'd0);
    check("rst_cmd_idx", {13'd0, cmd, fail_idx}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic script, all acknowledged.
    wr_entry(0, 4'd3, 16'h0000);
    wr_entry(1, 4'd3, 16'h23FF);
    wr_entry(2, 4'd3, 16'h2000);
    wr_entry(3, 4'd3, 16'h4002);
    plan = '{R_ACK, R_ACK, R_ACK, R_ACK};
    run_check(4, plan, "basic");

    // Negative acknowledge on entry 1.
    plan = '{R_ACK, R_NAK};
    run_check(4, plan, "nak");

    // Silent responder on a short-timeout entry: original plus one retry.
    wr_entry(0, 4'd0, 16'h0000);
    plan = '{R_NONE, R_NONE};
    run_check(4, plan, "tmo");
    if (sent_t.size() == 2) begin
      gap = sent_t[1] - sent_t[0];
      check("tmo_gap", {31'd0, (gap >= 16 && gap <= 18)}, 32'd1);
      gap = done_cyc - sent_t[0];
      check("tmo_done_t", {31'd0, (gap >= 30 && gap <= 36)}, 32'd1);
    end
    wr_entry(0, 4'd3, 16'h0000);

    // First attempt times out (with a stale ACK before cmd_sent), retry succeeds.
    plan = '{R_STALE, R_ACK, R_ACK, R_ACK, R_ACK};
    run_check(4, plan, "retry");

    // Abort while entry 2 awaits its response; start and write while busy are ignored.
    rc_plan = '{R_ACK, R_ACK, R_NONE};
    sent_q.delete();
    @(negedge clk);
    len = 4'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_sends(1, "abt1");
    start = 1'b1; wr_en = 1'b1; wr_addr = 3'd3; wr_data = {4'd3, 16'hBEEF};
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    wait_sends(3, "abt3");
    repeat (12) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abt_done", {31'd0, done}, 32'd1);
    check("abt_code", {30'd0, fail_code}, 32'd3);
    check("abt_idx", {29'd0, fail_idx}, 32'd2);
    check("abt_pass", {31'd0, pass}, 32'd0);
    exp_q = '{m_cmd[0], m_cmd[1], m_cmd[2]};
    check_sends("abt");
    @(negedge clk);
    check("abt_idle", {31'd0, busy}, 32'd0);

    // Empty script passes at once.
    plan = '{};
    run_check(0, plan, "len0");

    // Reset mid-run, then rerun from the retained script.
    rc_plan = '{R_ACK, R_ACK, R_ACK, R_ACK};
    sent_q.delete();
    @(negedge clk);
    len = 4'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_sends(2, "rst2");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_ctl", {29'd0, busy, done, send_cmd}, 32'd0);
    check("mrst_stat", {13'd0, cmd, fail_idx}, 32'd0);
    check("mrst_pc", {29'd0, pass, fail_code}, 32'd0);
    rc_plan.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    plan = '{R_ACK, R_ACK, R_ACK, R_ACK};
    run_check(4, plan, "after_rst");

    // Randomised scripts and response plans.
    for (int r = 0; r < 6; r++) begin
      int p;
      for (int a = 0; a < 8; a++)
        wr_entry(a, 4'(3 + $urandom_range(0, 1)), 16'($urandom_range(0, 65535)));
      n_len = $urandom_range(1, 8);
      plan.delete();
      for (int k = 0; k < 16; k++) begin
        p = $urandom_range(0, 9);
        plan.push_back(p < 8 ? R_ACK : (p == 8 ? R_NAK : R_NONE));
      end
      run_check(n_len, plan, $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
